ssp_uart_host: RTL and testbench
================================

SSP_UART_HOST -- requirements
Module: ssp_uart_host

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, number of Clk cycles per SCK half-period; legal range 1..255.
REQ-002 SHALL have ports: Clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have ports: Rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: cmd_vld  input  1  command valid.
REQ-005 SHALL have ports: cmd_rdy  output  1  command accepted when cmd_vld & cmd_rdy.
REQ-006 SHALL have ports: cmd_ra  input  3  target UART register address.
REQ-007 SHALL have ports: cmd_wnr  input  1  1 = write, 0 = read.
REQ-008 SHALL have ports: cmd_wdata  input  12  write data.
REQ-009 SHALL have ports: rsp_vld  output  1  one-cycle pulse, frame complete.
REQ-010 SHALL have ports: rsp_rdata  output  12  SSP_DO captured in the frame.
REQ-011 SHALL have ports: busy  output  1  frame in progress.
REQ-012 SHALL have ports: SSP_SSEL  output  1  slave select, high during frame.
REQ-013 SHALL have ports: SSP_SCK  output  1  serial clock, idle low.
REQ-014 SHALL have ports: SSP_RA  output  3  register address; SSP_WnR  output  1  command.
REQ-015 SHALL have ports: SSP_En  output  1  data phase; SSP_EOC  output  1  end of cycle.
REQ-016 SHALL have ports: SSP_DI  output  12  data to UART; SSP_DO  input  12  data from UART.

Function
REQ-017 SHALL implement FSM IDLE -> SETUP -> SHIFT -> HOLD -> DONE -> IDLE.
- IDLE: cmd_rdy=1, busy=0.
- All other states: cmd_rdy=0, busy=1.
REQ-018 On acceptance, SHALL register cmd_ra, cmd_wnr and cmd_wdata, and go to SETUP.
- SSP_RA, SSP_WnR and SSP_DI take the registered values and hold them stable until DONE exits.
- SSP_DI SHALL be driven as 0 when cmd_wnr=0.
REQ-019 SETUP SHALL assert SSP_SSEL with SSP_SCK low for CLK_DIV cycles, then enter SHIFT.
REQ-020 SHIFT SHALL produce exactly 16 SCK periods, each CLK_DIV cycles high followed by CLK_DIV cycles low.
- A 4-bit bit counter starts at 15 and decrements after each SCK falling edge.
- Bits 15..12 form the header phase; bits 11..0 form the data phase.
REQ-021 SSP_En SHALL be 1 exactly while the bit counter is 11..0 in SHIFT.
REQ-022 SSP_EOC SHALL be 1 exactly while the bit counter is 0 in SHIFT.
REQ-023 At the Clk edge where SCK rises with the bit counter at 0, SHALL capture SSP_DO into rsp_rdata.
- Write frames also capture.
REQ-024 After the 16th SCK falling edge, SHALL enter HOLD: SSP_SSEL=1, SCK low for CLK_DIV cycles.
REQ-025 DONE SHALL last one cycle: SSP_SSEL=0, rsp_vld=1. The next state is IDLE.
REQ-026 rsp_vld SHALL rise exactly 34*CLK_DIV cycles after the accepting edge.
- cmd_rdy SHALL be 1 on the following cycle.
- Back-to-back throughput is one frame per 34*CLK_DIV+1 cycles.
REQ-027 rsp_rdata SHALL hold its value until the next capture; rsp_vld has no back-pressure.
REQ-028 cmd_vld while not in IDLE SHALL be ignored (cmd_rdy=0); no command queuing.
REQ-029 With CLK_DIV=1, SCK SHALL toggle every Clk cycle with the same phase rules.
REQ-030 The divider counter SHALL be ceil(log2(CLK_DIV+1)) bits wide and SHALL reset to 0 at each phase change.

Reset
REQ-031 Rst low SHALL asynchronously force state IDLE and clear the divider and bit counters.
- Outputs forced: cmd_rdy=1, busy=0, rsp_vld=0, rsp_rdata=0.
- Outputs forced: SSP_SSEL=0, SSP_SCK=0, SSP_En=0, SSP_EOC=0, SSP_RA=0, SSP_WnR=0, SSP_DI=0.
REQ-032 Reset mid-frame SHALL abort the frame with no rsp_vld; the first command after Rst deasserts SHALL run a full, correct frame.

Verification
REQ-033 Write, CLK_DIV=2: ra=3, wnr=1, wdata=0xA5C.
- SSP_SSEL high for 68 cycles; 16 SCK pulses.
- SSP_En high for 48 cycles; SSP_EOC high for the last 4 SHIFT cycles.
- rsp_vld pulses 68 cycles after acceptance.
REQ-034 Read, CLK_DIV=2: ra=5, wnr=0, SSP_DO=0x3F1.
- SSP_DI=0 throughout the frame.
- rsp_rdata=0x3F1 with rsp_vld.
- If SSP_DO changes to 0x000 after the capture edge, rsp_rdata stays 0x3F1.
REQ-035 Back-to-back: cmd_vld held high with two commands queued upstream.
- Second acceptance occurs on the cycle after the first rsp_vld.
- A cmd_vld pulse mid-frame is not accepted.
REQ-036 CLK_DIV=1: read ra=7.
- SCK toggles every Clk cycle; 16 rising edges.
- rsp_vld 34 cycles after acceptance.
REQ-037 Rst asserted during bit 6 of a frame.
- All outputs go to reset values immediately; no rsp_vld.
- A write ra=1, wdata=0x001 after release completes normally.
REQ-038 Header check: in every frame, the first 4 SCK periods have SSP_En=0 and SSP_RA/SSP_WnR stable from SETUP through HOLD.

Source files
------------

// File: rtl/ssp_uart_host.sv
// SSP host bridge: turns one register command into a 16-bit serial frame
// (4-bit header, 12-bit data) toward a UART core and returns the sampled data.
module ssp_uart_host #(
    parameter int CLK_DIV = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        cmd_vld,
    output logic        cmd_rdy,
    input  logic [2:0]  cmd_ra,
    input  logic        cmd_wnr,
    input  logic [11:0] cmd_wdata,
    output logic        rsp_vld,
    output logic [11:0] rsp_rdata,
    output logic        busy,
    output logic        SSP_SSEL,
    output logic        SSP_SCK,
    output logic [2:0]  SSP_RA,
    output logic        SSP_WnR,
    output logic        SSP_En,
    output logic        SSP_EOC,
    output logic [11:0] SSP_DI,
    input  logic [11:0] SSP_DO
);

    localparam int DW = $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        DONE
    } state_t;

    state_t        state, state_n;
    logic [DW-1:0] div_q, div_n;
    logic [3:0]    bit_q, bit_n;
    logic          sck_q, sck_n;
    logic          div_end;
    logic          accept;
    logic          capture;

    assign div_end = (div_q == DIV_LAST);
    assign accept  = cmd_vld & cmd_rdy;
    // The low half of bit 1 ends on the same edge that raises SCK for bit 0.
    assign capture = (state == SHIFT) && div_end && !sck_q && (bit_q == 4'd1);

    always_comb begin
        state_n = state;
        div_n   = div_q;
        bit_n   = bit_q;
        sck_n   = sck_q;
        unique case (state)
            IDLE: begin
                if (cmd_vld) begin
                    state_n = SETUP;
                    div_n   = '0;
                end
            end
            SETUP: begin
                if (div_end) begin
                    state_n = SHIFT;
                    div_n   = '0;
                    sck_n   = 1'b1;
                    bit_n   = 4'd15;
                end else begin
                    div_n = div_q + 1'b1;
                end
            end
            SHIFT: begin
                if (div_end) begin
                    div_n = '0;
                    if (sck_q) begin
                        sck_n = 1'b0;
                    end else if (bit_q == 4'd0) begin
                        state_n = HOLD;
                    end else begin
                        sck_n = 1'b1;
                        bit_n = bit_q - 4'd1;
                    end
                end else begin
                    div_n = div_q + 1'b1;
                end
            end
            HOLD: begin
                if (div_end) begin
                    state_n = DONE;
                    div_n   = '0;
                end else begin
                    div_n = div_q + 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= IDLE;
            div_q <= '0;
            bit_q <= '0;
            sck_q <= 1'b0;
        end else begin
            state <= state_n;
            div_q <= div_n;
            bit_q <= bit_n;
            sck_q <= sck_n;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            SSP_RA    <= '0;
            SSP_WnR   <= 1'b0;
            SSP_DI    <= '0;
            rsp_rdata <= '0;
        end else begin
            if (accept) begin
                SSP_RA  <= cmd_ra;
                SSP_WnR <= cmd_wnr;
                SSP_DI  <= cmd_wnr ? cmd_wdata : 12'h000;
            end
            if (capture) begin
                rsp_rdata <= SSP_DO;
            end
        end
    end

    assign cmd_rdy  = (state == IDLE);
    assign busy     = (state != IDLE);
    assign rsp_vld  = (state == DONE);
    assign SSP_SSEL = (state == SETUP) || (state == SHIFT) || (state == HOLD);
    assign SSP_SCK  = sck_q;
    assign SSP_En   = (state == SHIFT) && (bit_q <= 4'd11);
    assign SSP_EOC  = (state == SHIFT) && (bit_q == 4'd0);

endmodule

// File: tb/tb_ssp_uart_host.sv
// Bench for ssp_uart_host: two instances (CLK_DIV=2 and CLK_DIV=1) checked
// cycle by cycle against a frame timing model derived from the phase rules.
module tb_ssp_uart_host;

    logic        Clk;
    logic        Rst [2];
    logic        cmd_vld [2];
    logic        cmd_rdy [2];
    logic [2:0]  cmd_ra [2];
    logic        cmd_wnr [2];
    logic [11:0] cmd_wdata [2];
    logic        rsp_vld [2];
    logic [11:0] rsp_rdata [2];
    logic        busy [2];
    logic        SSP_SSEL [2];
    logic        SSP_SCK [2];
    logic [2:0]  SSP_RA [2];
    logic        SSP_WnR [2];
    logic        SSP_En [2];
    logic        SSP_EOC [2];
    logic [11:0] SSP_DI [2];
    logic [11:0] SSP_DO [2];

    int total = 0;
    int bad   = 0;

    localparam logic [22:0] RST_VEC = 23'h020000;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ssp_uart_host #(.CLK_DIV(g == 0 ? 2 : 1)) u_dut (
            .Clk       (Clk),
            .Rst       (Rst[g]),
            .cmd_vld   (cmd_vld[g]),
            .cmd_rdy   (cmd_rdy[g]),
            .cmd_ra    (cmd_ra[g]),
            .cmd_wnr   (cmd_wnr[g]),
            .cmd_wdata (cmd_wdata[g]),
            .rsp_vld   (rsp_vld[g]),
            .rsp_rdata (rsp_rdata[g]),
            .busy      (busy[g]),
            .SSP_SSEL  (SSP_SSEL[g]),
            .SSP_SCK   (SSP_SCK[g]),
            .SSP_RA    (SSP_RA[g]),
            .SSP_WnR   (SSP_WnR[g]),
            .SSP_En    (SSP_En[g]),
            .SSP_EOC   (SSP_EOC[g]),
            .SSP_DI    (SSP_DI[g]),
            .SSP_DO    (SSP_DO[g])
        );
    end

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [22:0] obs(int k);
        return {SSP_SSEL[k], SSP_SCK[k], SSP_En[k], SSP_EOC[k], rsp_vld[k],
                cmd_rdy[k], busy[k], SSP_WnR[k], SSP_RA[k], SSP_DI[k]};
    endfunction

    // Expected pins n cycles after the accepting edge.
    function automatic logic [22:0] expv(int d, int n, logic [2:0] ra,
                                         logic wnr, logic [11:0] wd);
        logic ssel, sck, en, eoc, vld;
        logic [11:0] di;
        int m, b;
        ssel = 1'b0; sck = 1'b0; en = 1'b0; eoc = 1'b0; vld = 1'b0;
        di = wnr ? wd : 12'h000;
        if (n < d) begin
            ssel = 1'b1;
        end else if (n < 33 * d) begin
            ssel = 1'b1;
            m    = n - d;
            b    = 15 - m / (2 * d);
            sck  = (m % (2 * d)) < d;
            en   = (b <= 11);
            eoc  = (b == 0);
        end else if (n < 34 * d) begin
            ssel = 1'b1;
        end else begin
            vld = 1'b1;
        end
        return {ssel, sck, en, eoc, vld, 1'b0, 1'b1, wnr, ra, di};
    endfunction

    task automatic run_frame(int k, logic [2:0] ra, logic wnr,
                             logic [11:0] wd, logic [11:0] dov, bit hold);
        int d;
        int c;
        logic [31:0] r;
        d = (k == 0) ? 2 : 1;
        c = 31 * d;
        cmd_vld[k]   = 1'b1;
        cmd_ra[k]    = ra;
        cmd_wnr[k]   = wnr;
        cmd_wdata[k] = wd;
        SSP_DO[k]    = ~dov;
        chk("rdy_before", cmd_rdy[k], 1);
        for (int n = 0; n <= 34 * d; n++) begin
            @(negedge Clk);
            if (n == 0) begin
                if (hold) begin
                    r = $urandom;
                    cmd_ra[k]    = r[2:0];
                    cmd_wnr[k]   = r[3];
                    cmd_wdata[k] = r[15:4];
                end else begin
                    cmd_vld[k] = 1'b0;
                end
            end
            if (n == c - 1) SSP_DO[k] = dov;
            if (n == c) SSP_DO[k] = 12'h000;
            chk("frame", obs(k), expv(d, n, ra, wnr, wd));
            if (n == 34 * d) chk("rdata", rsp_rdata[k], dov);
        end
        @(negedge Clk);
        chk("rdata_hold", rsp_rdata[k], dov);
        chk("idle", obs(k), {5'b0, 1'b1, 1'b0, wnr, ra,
                             wnr ? wd : 12'h000});
    endtask

    task automatic rst_mid(int k);
        int d;
        int seen;
        logic [31:0] r;
        d = (k == 0) ? 2 : 1;
        r = $urandom;
        cmd_vld[k]   = 1'b1;
        cmd_ra[k]    = 3'd2;
        cmd_wnr[k]   = 1'b1;
        cmd_wdata[k] = r[11:0];
        for (int n = 0; n <= d + 18 * d + 1; n++) begin
            @(negedge Clk);
            if (n == 0) cmd_vld[k] = 1'b0;
        end
        chk("in_bit6", {SSP_En[k], SSP_SSEL[k]}, 2'b11);
        #1 Rst[k] = 1'b0;
        #1;
        chk("rst_now", obs(k), RST_VEC);
        chk("rst_rdata", rsp_rdata[k], 0);
        @(negedge Clk);
        Rst[k] = 1'b1;
        seen = 0;
        for (int n = 0; n < 34 * d + 4; n++) begin
            @(negedge Clk);
            if (rsp_vld[k]) seen++;
        end
        chk("no_vld", seen, 0);
        chk("rst_idle", obs(k), RST_VEC);
    endtask

    initial begin
        logic [31:0] r;
        for (int k = 0; k < 2; k++) begin
            Rst[k]       = 1'b0;
            cmd_vld[k]   = 1'b0;
            cmd_ra[k]    = '0;
            cmd_wnr[k]   = 1'b0;
            cmd_wdata[k] = '0;
            SSP_DO[k]    = '0;
        end
        repeat (3) @(negedge Clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset_pins", obs(k), RST_VEC);
            chk("reset_rdata", rsp_rdata[k], 0);
            Rst[k] = 1'b1;
        end
        @(negedge Clk);

        run_frame(0, 3'd3, 1'b1, 12'hA5C, 12'h6B2, 1'b0);
        run_frame(0, 3'd5, 1'b0, 12'hFFF, 12'h3F1, 1'b0);
        run_frame(0, 3'd6, 1'b1, 12'h123, 12'h456, 1'b1);
        run_frame(0, 3'd2, 1'b0, 12'h000, 12'h9E7, 1'b0);

        for (int i = 0; i < 6; i++) begin
            r = $urandom;
            run_frame(0, r[2:0], r[3], r[15:4], r[27:16], r[28]);
        end
        cmd_vld[0] = 1'b0;
        @(negedge Clk);

        run_frame(1, 3'd7, 1'b0, 12'h5A5, 12'hC3D, 1'b0);
        for (int i = 0; i < 4; i++) begin
            r = $urandom;
            run_frame(1, r[2:0], r[3], r[15:4], r[27:16], r[28]);
        end
        cmd_vld[1] = 1'b0;
        @(negedge Clk);

        rst_mid(0);
        r = $urandom;
        run_frame(0, 3'd1, 1'b1, 12'h001, r[11:0], 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
